// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard controller
package hazard_pkg;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  localparam logic [4:0] ZERO_REG = 5'd0;

  // A source register matches a destination only if it is really read and is not $0.
  function automatic logic reg_match(input logic used, input logic [4:0] src,
                                     input logic [4:0] dst);
    return used && (src != ZERO_REG) && (src == dst);
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_timer.sv
// rtl/hazard_ctrl_md_busy_timer.sv - mult/div busy window tracker
module md_busy_timer
  import hazard_pkg::*;
#(
  parameter int MD_LAT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy
);

  localparam logic [3:0] LAT = 4'(MD_LAT);

  md_state_t  state, state_nxt;
  logic [3:0] md_cnt, md_cnt_nxt;

  // State and down-counter registers; reset abandons any running operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= MD_IDLE;
      md_cnt <= 4'd0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
    end
  end

  // Next state: a start always (re)loads the latency, otherwise count down to idle.
  always_comb begin
    state_nxt  = state;
    md_cnt_nxt = md_cnt;
    case (state)
      MD_IDLE: begin
        if (start) begin
          state_nxt  = MD_BUSY;
          md_cnt_nxt = LAT;
        end
      end
      MD_BUSY: begin
        if (start) begin
          md_cnt_nxt = LAT;
        end else if (md_cnt == 4'd1) begin
          state_nxt  = MD_IDLE;
          md_cnt_nxt = 4'd0;
        end else begin
          md_cnt_nxt = md_cnt - 4'd1;
        end
      end
      default: begin
        state_nxt  = MD_IDLE;
        md_cnt_nxt = 4'd0;
      end
    endcase
  end

  assign busy = (state == MD_BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use, branch-operand, mult/div and redirect hazard control
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       IFID_rs,
  input  logic [4:0]       IFID_rt,
  input  logic             UseRsD,
  input  logic             UseRtD,
  input  logic             BranchD,
  input  logic             MdOpD,
  input  logic             TakenD,
  input  logic [4:0]       IDEX_WA,
  input  logic             RegWriteE,
  input  logic             MemReadE,
  input  logic             MdStartE,
  input  logic [4:0]       EXMEM_WA,
  input  logic             MemReadM,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  logic rs_e, rt_e, rs_m, rt_m;
  logic lu_stall, br_stall, md_stall, stall;

  md_busy_timer #(.MD_LAT(MD_LAT)) u_md (
    .clk  (clk),
    .reset(reset),
    .start(MdStartE),
    .busy (md_busy)
  );

  // Operand matches against EX and MEM destinations, and the stall they cause.
  always_comb begin
    rs_e     = reg_match(UseRsD, IFID_rs, IDEX_WA);
    rt_e     = reg_match(UseRtD, IFID_rt, IDEX_WA);
    rs_m     = reg_match(UseRsD, IFID_rs, EXMEM_WA);
    rt_m     = reg_match(UseRtD, IFID_rt, EXMEM_WA);
    lu_stall = MemReadE && (rs_e || rt_e);
    br_stall = BranchD && ((RegWriteE && (rs_e || rt_e)) || (MemReadM && (rs_m || rt_m)));
    md_stall = MdOpD && md_busy;
    // Outputs stay quiet while reset is held, even if the inputs look hazardous.
    stall    = (lu_stall || br_stall || md_stall) && !reset;
  end

  assign StallF = stall;
  assign StallD = stall;
  assign FlushE = stall;
  // A stalled branch has not really resolved, so its redirect waits.
  assign FlushD = TakenD && !stall && !reset;

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  IFID_rs, IFID_rt, IDEX_WA, EXMEM_WA;
  logic        UseRsD, UseRtD, BranchD, MdOpD, TakenD;
  logic        RegWriteE, MemReadE, MdStartE, MemReadM;
  logic        StallF, StallD, FlushD, FlushE, md_busy;
  logic [15:0] stall_cnt;
  logic        s_StallF, s_StallD, s_FlushD, s_FlushE, s_md_busy;
  logic [1:0]  s_stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MD_LAT(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .IFID_rs(IFID_rs), .IFID_rt(IFID_rt), .UseRsD(UseRsD), .UseRtD(UseRtD),
    .BranchD(BranchD), .MdOpD(MdOpD), .TakenD(TakenD),
    .IDEX_WA(IDEX_WA), .RegWriteE(RegWriteE), .MemReadE(MemReadE), .MdStartE(MdStartE),
    .EXMEM_WA(EXMEM_WA), .MemReadM(MemReadM),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  hazard_ctrl #(.MD_LAT(4), .CNT_W(2)) dut_small (
    .clk(clk), .reset(reset),
    .IFID_rs(IFID_rs), .IFID_rt(IFID_rt), .UseRsD(UseRsD), .UseRtD(UseRtD),
    .BranchD(BranchD), .MdOpD(MdOpD), .TakenD(TakenD),
    .IDEX_WA(IDEX_WA), .RegWriteE(RegWriteE), .MemReadE(MemReadE), .MdStartE(MdStartE),
    .EXMEM_WA(EXMEM_WA), .MemReadM(MemReadM),
    .StallF(s_StallF), .StallD(s_StallD), .FlushD(s_FlushD), .FlushE(s_FlushE),
    .md_busy(s_md_busy), .stall_cnt(s_stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    IFID_rs = 0; IFID_rt = 0; UseRsD = 0; UseRtD = 0; BranchD = 0; MdOpD = 0;
    TakenD = 0; IDEX_WA = 0; RegWriteE = 0; MemReadE = 0; MdStartE = 0;
    EXMEM_WA = 0; MemReadM = 0;
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // let new inputs settle before sampling (still well away from the edge)
  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    tick();
    chk("rst_md_busy", md_busy, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    MemReadE = 1; IDEX_WA = 8; UseRsD = 1; IFID_rs = 8;
    settle();
    chk("rst_stall_masked", StallF, 0);
    chk("rst_flushe_masked", FlushE, 0);
    reset = 1'b0;
    settle();

    // load-use: lw $8 in EX, add reads $8
    RegWriteE = 1;
    settle();
    chk("lu_stallf", StallF, 1);
    chk("lu_stalld", StallD, 1);
    chk("lu_flushe", FlushE, 1);
    tick();
    MemReadE = 0; RegWriteE = 0; IDEX_WA = 0; EXMEM_WA = 8; MemReadM = 1;
    settle();
    chk("lu_released", StallD, 0);
    chk("lu_cnt", stall_cnt, 1);

    // beq $9,$0 with lw $9 in EX: two stall cycles, redirect held back
    clear_inputs();
    tick();
    BranchD = 1; UseRsD = 1; UseRtD = 1; IFID_rs = 9; IFID_rt = 0;
    IDEX_WA = 9; MemReadE = 1; RegWriteE = 1; TakenD = 1;
    settle();
    chk("brld_stall1", StallD, 1);
    chk("brld_noflush1", FlushD, 0);
    tick();
    IDEX_WA = 0; MemReadE = 0; RegWriteE = 0; EXMEM_WA = 9; MemReadM = 1;
    settle();
    chk("brld_stall2", StallD, 1);
    chk("brld_noflush2", FlushD, 0);
    tick();
    EXMEM_WA = 0; MemReadM = 0;
    settle();
    chk("brld_go", StallD, 0);
    chk("brld_flushd", FlushD, 1);
    chk("brld_cnt", stall_cnt, 3);

    // branch on ALU result in EX: one stall, then forwards from MEM
    clear_inputs();
    tick();
    BranchD = 1; UseRsD = 1; IFID_rs = 10; IDEX_WA = 10; RegWriteE = 1;
    settle();
    chk("bralu_stall", StallD, 1);
    tick();
    IDEX_WA = 0; RegWriteE = 0; EXMEM_WA = 10;
    settle();
    chk("bralu_go", StallD, 0);

    // hazards against $0 never stall
    clear_inputs();
    MemReadE = 1; RegWriteE = 1; IDEX_WA = 0; UseRsD = 1; IFID_rs = 0;
    BranchD = 1; UseRtD = 1; IFID_rt = 0; MemReadM = 1; EXMEM_WA = 0;
    settle();
    chk("zero_no_stall", StallD, 0);

    // mult in EX at t; mfhi in ID from t+1
    clear_inputs();
    tick();
    MdStartE = 1;
    settle();
    chk("md_t_idle", md_busy, 0);
    tick();
    MdStartE = 0; MdOpD = 1;
    for (int k = 1; k <= 4; k++) begin
      settle();
      chk($sformatf("md_busy_t%0d", k), md_busy, 1);
      chk($sformatf("md_stall_t%0d", k), StallD, 1);
      tick();
    end
    settle();
    chk("md_done_busy", md_busy, 0);
    chk("md_done_stall", StallD, 0);
    chk("md_cnt", stall_cnt, 8);

    // back-to-back start while busy reloads the latency
    clear_inputs();
    MdStartE = 1;
    tick();
    MdStartE = 0;
    tick();
    MdStartE = 1;
    tick();
    MdStartE = 0;
    for (int k = 3; k <= 6; k++) begin
      settle();
      chk($sformatf("md_reload_t%0d", k), md_busy, 1);
      tick();
    end
    settle();
    chk("md_reload_idle", md_busy, 0);

    // reset in the middle of BUSY
    clear_inputs();
    MdStartE = 1;
    tick();
    MdStartE = 0; MdOpD = 1;
    tick();
    settle();
    chk("mdrst_pre", StallD, 1);
    reset = 1'b1;
    settle();
    chk("mdrst_busy", md_busy, 0);
    chk("mdrst_stall", StallD, 0);
    chk("mdrst_cnt", stall_cnt, 0);
    tick();
    reset = 1'b0;
    settle();
    chk("mdrst_after_stall", StallD, 0);
    tick();
    chk("mdrst_after_busy", md_busy, 0);
    chk("mdrst_after_cnt", stall_cnt, 0);

    // stall with a taken branch, held 5 cycles; narrow counter saturates
    clear_inputs();
    MemReadE = 1; IDEX_WA = 12; UseRtD = 1; IFID_rt = 12; TakenD = 1;
    settle();
    chk("take_stall_flushd", FlushD, 0);
    chk("take_stall_flushe", FlushE, 1);
    for (int k = 0; k < 5; k++) tick();
    chk("sat_small_cnt", s_stall_cnt, 3);
    chk("sat_wide_cnt", stall_cnt, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core. It sits beside the forwarding unit, which covers every case a mux can resolve. This block covers the cases a mux cannot:
- load-use hazards
- branch/jr operands that are not ready in ID
- HI/LO access while the multi-cycle multiply/divide unit is busy
- control-flow redirects

It drives the stall and flush enables of the IF/ID and ID/EX pipeline registers. It also owns the MD busy counter and a stall performance counter.

## Interface
Parameters:
- MD_LAT, 4: cycles the mult/div unit needs after the instruction leaves EX (legal range 1..15).
- CNT_W, 16: width of the stall performance counter.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- IFID_rs, IFID_rt  in  5 each  source registers of the instruction in ID.
- UseRsD, UseRtD  in  1 each  the ID instruction actually reads rs / rt.
- BranchD  in  1  the ID instruction is beq/bne/jr (compares or reads its operands in ID).
- MdOpD  in  1  the ID instruction is mult/div/mfhi/mflo/mthi/mtlo.
- TakenD  in  1  ID resolved a taken branch or jump this cycle.
- IDEX_WA  in  5  destination register of the EX instruction.
- RegWriteE, MemReadE  in  1 each  the EX instruction writes a register / is a load.
- MdStartE  in  1  the EX instruction is mult/div and is valid (not a bubble).
- EXMEM_WA  in  5  destination register of the MEM instruction.
- MemReadM  in  1  the MEM instruction is a load.
- StallF, StallD  out  1 each  hold the PC / hold IF/ID.
- FlushD, FlushE  out  1 each  clear IF/ID / insert a bubble into ID/EX.
- md_busy  out  1  the mult/div unit is running.
- stall_cnt  out  CNT_W  saturating count of stalled cycles.

## Operation
Match terms (a match requires the register to be nonzero):
- rsE = UseRsD && IFID_rs==IDEX_WA; rtE is the same for rt.
- rsM = UseRsD && IFID_rs==EXMEM_WA; rtM is the same for rt.

Stall sources (combinational):
- lu_stall = MemReadE && (rsE||rtE).
- br_stall = BranchD && ((RegWriteE && (rsE||rtE)) || (MemReadM && (rsM||rtM))).
- md_stall = MdOpD && md_busy.
- stall = lu_stall | br_stall | md_stall.

Outputs:
- StallF = StallD = FlushE = stall.
- FlushD = TakenD && !stall. A stalled branch is not yet resolved, so its TakenD is ignored.

MD state machine, states IDLE and BUSY, with a down-counter `md_cnt` of 4 bits:
- IDLE, MdStartE=1: load md_cnt=MD_LAT and go to BUSY.
- BUSY: decrement md_cnt each cycle. When md_cnt==1, go to IDLE and reset the count to 0.
- BUSY, MdStartE=1: reload md_cnt=MD_LAT and stay in BUSY. This is a protocol error and cannot occur while md_stall works; it is defined for robustness.
- md_busy = (state==BUSY).

stall_cnt increments every cycle in which stall=1, and saturates at all-ones.

## Timing
- All stall/flush outputs are combinational in the current-cycle inputs and registered md state. There is no added latency.
- A load-use hazard produces exactly 1 stall cycle.
- A branch depending on a load in EX stalls 2 cycles: one for lu/br in EX, one for MemReadM in MEM.
- A branch depending on an ALU result in EX stalls 1 cycle. The value then forwards from MEM.
- MD busy window:
  - MdStartE is high in cycle t; md_busy is high in cycles t+1 .. t+MD_LAT.
  - An MdOpD instruction in ID during that window stalls.
  - The first cycle it can proceed is t+MD_LAT+1.
- Stall and TakenD in the same cycle: the stall wins and FlushD=0.
- Reset, applied at any time, including mid-BUSY:
  - State goes to IDLE, md_cnt=0, md_busy=0, stall_cnt=0.
  - Stall and flush outputs are 0 while reset is high.
  - Any in-flight MD operation is abandoned.

## Structure
- Shared package `hazard_pkg` holds:
  - the MD state encoding (IDLE=0, BUSY=1);
  - the constant ZERO_REG=5'd0.
- Natural sub-module `md_busy_timer`: the state machine, md_cnt and md_busy.
- The top level holds the match/stall logic and stall_cnt.

## Test plan
- lw $8 in EX (MemReadE=1, IDEX_WA=8); add in ID with UseRsD=1, IFID_rs=8 -> StallF=StallD=FlushE=1 for exactly 1 cycle, then 0; stall_cnt=1.
- beq $9,$0 in ID (BranchD=1); lw $9 in EX -> stall in 2 consecutive cycles: lu_stall, then MemReadM with EXMEM_WA=9. FlushD=1 only when TakenD is presented after the stall clears.
- Hazard to $0: IDEX_WA=0 with MemReadE=1 and IFID_rs=0 -> no stall.
- MD with MD_LAT=4: MdStartE pulse at t; mfhi in ID from t+1 -> md_busy and StallD high for t+1..t+4, and both 0 at t+5.
- Reset mid-BUSY: assert reset at t+2 -> md_busy=0 and stall outputs=0 immediately. After release, mfhi proceeds with no stall.
- Stall together with TakenD=1 -> FlushD=0 and FlushE=1. Set CNT_W=2 and hold the stall for 5 cycles -> stall_cnt saturates at 3.
